rr_issue_arbiter: RTL and testbench
===================================

Name: rr_issue_arbiter

Overview:
- Parametrised round-robin arbiter with a registered grant. It selects one of NUM_REQ requesters (warps) each cycle for the issue stage.
- Priority rotates from the most-recently-granted requester. This replaces the fixed 8-wide up/down rotate-and-priority-encode structure.
- The grant is held in an output register under a valid/ready handshake. The round-robin pointer updates only when a new grant is loaded.
- Sits between the per-warp IBuffer/scoreboard ready signals and the issue/dispatch stage.

Parameters:
- NUM_REQ, 8, number of requesters; any value >= 2, need not be a power of two.
- ID_W, $clog2(NUM_REQ), width of the binary grant index.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  request vector; bit i high = requester i eligible this cycle.
- flush  input  1  synchronous; drops any held grant without moving the pointer.
- grant_ready  input  1  downstream accepts the current grant this cycle.
- grant_valid  output  1  grant register holds a valid grant.
- grant_onehot  output  NUM_REQ  one-hot granted requester; all zero when grant_valid=0.
- grant_id  output  ID_W  binary index of the granted requester; 0 when grant_valid=0.
- mr_ptr  output  NUM_REQ  one-hot most-recently-granted pointer (debug/scoreboard use).

Behaviour:
- Reset (async, rst=1):
  - grant_valid=0, grant_onehot=0, grant_id=0.
  - mr_ptr=one-hot bit NUM_REQ-1, so requester 0 has highest priority first.
- Arbitration (combinational on req and mr_ptr):
  - Requesters are searched starting at mr_index+1, ascending, wrapping modulo NUM_REQ; mr_index itself is searched last.
  - The winner is the first requester found with req=1.
  - For non-power-of-two NUM_REQ, the wrap goes from NUM_REQ-1 to 0; no phantom slots exist.
- Load condition: load = (!grant_valid || grant_ready) && !flush.
- On load with req != 0:
  - grant_valid<=1, grant_onehot<=winner, grant_id<=index(winner).
  - mr_ptr<=winner.
- On load with req == 0:
  - grant_valid<=0, grant_onehot<=0, grant_id<=0.
  - mr_ptr unchanged.
- Hold (grant_valid=1, grant_ready=0, flush=0):
  - All outputs and mr_ptr are held stable, even if the granted req bit deasserts.
  - Downstream qualifies the grant itself.
- Flush:
  - Has priority over load and hold: grant_valid<=0, grant_onehot<=0, grant_id<=0.
  - mr_ptr unchanged; no new grant in that cycle.
  - flush and grant_ready together: flush wins, and the accept is still treated as consumed.
- Latency:
  - A req asserted in cycle t, with the register free or accepted in t, appears as grant_valid in t+1.
  - Back-to-back accepts give one new grant per cycle (full throughput).
- Pointer rule: mr_ptr is always exactly one-hot, both after reset and in operation. No zero or multi-hot encodings exist, so the illegal-input case of the old rotators cannot occur.
- Fairness: with all req bits held high and grant_ready=1, every requester is granted exactly once in any NUM_REQ consecutive grants.
- Mid-operation reset clears a held grant immediately (async); mr_ptr returns to bit NUM_REQ-1.

Test Plan:
- Reset then req=8'hFF, grant_ready=1 for 10 cycles -> grant_id sequence 0,1,2,3,4,5,6,7,0,1 starting the cycle after req rises; mr_ptr tracks each grant.
- Single requester: req=8'b0010_0000 from reset -> grant_id=5 every cycle while grant_ready=1; mr_ptr=8'b0010_0000.
- Backpressure: req=8'hFF, grant_id=2 held with grant_ready=0 for 3 cycles while req changes to 8'h01 -> grant_id stays 2, mr_ptr stays bit 2. Then grant_ready=1 -> next grant_id=0.
- Wrap/skip: mr_ptr at bit 6, req=8'b0100_0001 -> grant 0 (not 6). Next cycle -> grant 6.
- Flush: grant_valid=1 with grant_id=3, assert flush with grant_ready=0 -> next cycle grant_valid=0, mr_ptr still bit 3. With req=8'hFF the following grant is 4.
- NUM_REQ=5: all requesting, grant_ready=1 -> grant_id sequence 0,1,2,3,4,0. Async rst mid-stream -> outputs zero immediately, restart at 0.

Source files
------------

// File: rtl/rr_issue_arbiter.sv
// rtl/rr_issue_arbiter.sv - round-robin issue arbiter with registered grant
module rr_issue_arbiter #(
  parameter int NUM_REQ = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               flush,
  input  logic               grant_ready,
  output logic               grant_valid,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [ID_W-1:0]    grant_id,
  output logic [NUM_REQ-1:0] mr_ptr
);

  localparam logic [NUM_REQ-1:0] ONE     = NUM_REQ'(1);
  localparam logic [NUM_REQ-1:0] PTR_RST = {1'b1, {(NUM_REQ-1){1'b0}}};

  logic               grant_valid_q, grant_valid_d;
  logic [NUM_REQ-1:0] grant_onehot_q, grant_onehot_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [NUM_REQ-1:0] mr_ptr_q, mr_ptr_d;

  logic [NUM_REQ-1:0] hi_mask;
  logic [NUM_REQ-1:0] req_hi;
  logic [NUM_REQ-1:0] lowest_hi;
  logic [NUM_REQ-1:0] lowest_all;
  logic [NUM_REQ-1:0] win;
  logic [ID_W-1:0]    win_id;
  logic               load;

  // Pick the lowest requester strictly above the pointer, else wrap to the lowest overall.
  // When the pointer sits on the top bit the shift drops out of the vector, so the
  // upper mask is empty and the search starts at 0 with no phantom slots.
  always_comb begin
    hi_mask    = ~((mr_ptr_q << 1) - ONE);
    req_hi     = req & hi_mask;
    lowest_hi  = req_hi & (~req_hi + ONE);
    lowest_all = req & (~req + ONE);
    win        = (|req_hi) ? lowest_hi : lowest_all;
  end

  // Binary index of the one-hot winner.
  always_comb begin
    win_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win[i]) win_id = ID_W'(i);
    end
  end

  // Next-state: flush clears without touching the pointer, load refreshes, otherwise hold.
  always_comb begin
    load           = (!grant_valid_q || grant_ready) && !flush;
    grant_valid_d  = grant_valid_q;
    grant_onehot_d = grant_onehot_q;
    grant_id_d     = grant_id_q;
    mr_ptr_d       = mr_ptr_q;
    if (flush) begin
      grant_valid_d  = 1'b0;
      grant_onehot_d = '0;
      grant_id_d     = '0;
    end else if (load) begin
      if (|req) begin
        grant_valid_d  = 1'b1;
        grant_onehot_d = win;
        grant_id_d     = win_id;
        mr_ptr_d       = win;
      end else begin
        grant_valid_d  = 1'b0;
        grant_onehot_d = '0;
        grant_id_d     = '0;
      end
    end
  end

  // Grant register and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_valid_q  <= 1'b0;
      grant_onehot_q <= '0;
      grant_id_q     <= '0;
      mr_ptr_q       <= PTR_RST;
    end else begin
      grant_valid_q  <= grant_valid_d;
      grant_onehot_q <= grant_onehot_d;
      grant_id_q     <= grant_id_d;
      mr_ptr_q       <= mr_ptr_d;
    end
  end

  assign grant_valid  = grant_valid_q;
  assign grant_onehot = grant_onehot_q;
  assign grant_id     = grant_id_q;
  assign mr_ptr       = mr_ptr_q;

endmodule

// File: tb/tb_rr_issue_arbiter.sv
// tb/tb_rr_issue_arbiter.sv - directed bench for rr_issue_arbiter (8- and 5-wide)
module tb_rr_issue_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       flush;
  logic       grant_ready;
  logic       grant_valid;
  logic [7:0] grant_onehot;
  logic [2:0] grant_id;
  logic [7:0] mr_ptr;

  logic       rst5;
  logic [4:0] req5;
  logic       flush5;
  logic       ready5;
  logic       valid5;
  logic [4:0] onehot5;
  logic [2:0] id5;
  logic [4:0] mr5;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  rr_issue_arbiter #(.NUM_REQ(8)) dut (
    .clk(clk), .rst(rst), .req(req), .flush(flush), .grant_ready(grant_ready),
    .grant_valid(grant_valid), .grant_onehot(grant_onehot), .grant_id(grant_id), .mr_ptr(mr_ptr)
  );

  rr_issue_arbiter #(.NUM_REQ(5)) dut5 (
    .clk(clk), .rst(rst5), .req(req5), .flush(flush5), .grant_ready(ready5),
    .grant_valid(valid5), .grant_onehot(onehot5), .grant_id(id5), .mr_ptr(mr5)
  );

  // advance to 1 time unit after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 8'h00;
    flush = 1'b0;
    grant_ready = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [19:0] exp;
    rst = 1'b1;
    req = 8'h00;
    flush = 1'b0;
    grant_ready = 1'b0;
    #3;
    exp = {1'b0, 8'h00, 3'd0, 8'h80};
    vecs++;
    if ({grant_valid, grant_onehot, grant_id, mr_ptr} !== exp) begin
      $display("FAIL reset got %h want %h", {grant_valid, grant_onehot, grant_id, mr_ptr}, exp);
      errs++;
    end
    rst = 1'b0;
  endtask

  task automatic test_rr_all();
    logic [19:0] exp;
    int          k;
    do_reset();
    cyc();
    req = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      cyc();
      k = i % 8;
      exp = {1'b1, 8'(1 << k), 3'(k), 8'(1 << k)};
      vecs++;
      if ({grant_valid, grant_onehot, grant_id, mr_ptr} !== exp) begin
        $display("FAIL rr_all[%0d] got %h want %h", i, {grant_valid, grant_onehot, grant_id, mr_ptr}, exp);
        errs++;
      end
    end
  endtask

  task automatic test_single();
    logic [19:0] exp;
    do_reset();
    req = 8'b0010_0000;
    exp = {1'b1, 8'h20, 3'd5, 8'h20};
    for (int i = 0; i < 4; i++) begin
      cyc();
      vecs++;
      if ({grant_valid, grant_onehot, grant_id, mr_ptr} !== exp) begin
        $display("FAIL single[%0d] got %h want %h", i, {grant_valid, grant_onehot, grant_id, mr_ptr}, exp);
        errs++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [19:0] exp;
    do_reset();
    req = 8'hFF;
    cyc();
    cyc();
    cyc();
    grant_ready = 1'b0;
    req = 8'h01;
    exp = {1'b1, 8'h04, 3'd2, 8'h04};
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if ({grant_valid, grant_onehot, grant_id, mr_ptr} !== exp) begin
        $display("FAIL hold[%0d] got %h want %h", i, {grant_valid, grant_onehot, grant_id, mr_ptr}, exp);
        errs++;
      end
      cyc();
    end
    grant_ready = 1'b1;
    cyc();
    exp = {1'b1, 8'h01, 3'd0, 8'h01};
    vecs++;
    if ({grant_valid, grant_onehot, grant_id, mr_ptr} !== exp) begin
      $display("FAIL release got %h want %h", {grant_valid, grant_onehot, grant_id, mr_ptr}, exp);
      errs++;
    end
  endtask

  task automatic test_wrap();
    logic [19:0] exp;
    do_reset();
    req = 8'b0100_0000;
    cyc();
    req = 8'b0100_0001;
    cyc();
    exp = {1'b1, 8'h01, 3'd0, 8'h01};
    vecs++;
    if ({grant_valid, grant_onehot, grant_id, mr_ptr} !== exp) begin
      $display("FAIL wrap0 got %h want %h", {grant_valid, grant_onehot, grant_id, mr_ptr}, exp);
      errs++;
    end
    cyc();
    exp = {1'b1, 8'h40, 3'd6, 8'h40};
    vecs++;
    if ({grant_valid, grant_onehot, grant_id, mr_ptr} !== exp) begin
      $display("FAIL wrap6 got %h want %h", {grant_valid, grant_onehot, grant_id, mr_ptr}, exp);
      errs++;
    end
  endtask

  task automatic test_flush();
    logic [19:0] exp;
    do_reset();
    req = 8'b0000_1000;
    cyc();
    req = 8'hFF;
    grant_ready = 1'b0;
    flush = 1'b1;
    cyc();
    exp = {1'b0, 8'h00, 3'd0, 8'h08};
    vecs++;
    if ({grant_valid, grant_onehot, grant_id, mr_ptr} !== exp) begin
      $display("FAIL flush got %h want %h", {grant_valid, grant_onehot, grant_id, mr_ptr}, exp);
      errs++;
    end
    flush = 1'b0;
    grant_ready = 1'b1;
    cyc();
    exp = {1'b1, 8'h10, 3'd4, 8'h10};
    vecs++;
    if ({grant_valid, grant_onehot, grant_id, mr_ptr} !== exp) begin
      $display("FAIL post_flush got %h want %h", {grant_valid, grant_onehot, grant_id, mr_ptr}, exp);
      errs++;
    end
    flush = 1'b1;
    cyc();
    exp = {1'b0, 8'h00, 3'd0, 8'h10};
    vecs++;
    if ({grant_valid, grant_onehot, grant_id, mr_ptr} !== exp) begin
      $display("FAIL flush_ready got %h want %h", {grant_valid, grant_onehot, grant_id, mr_ptr}, exp);
      errs++;
    end
    flush = 1'b0;
    cyc();
    exp = {1'b1, 8'h20, 3'd5, 8'h20};
    vecs++;
    if ({grant_valid, grant_onehot, grant_id, mr_ptr} !== exp) begin
      $display("FAIL after_flush_ready got %h want %h", {grant_valid, grant_onehot, grant_id, mr_ptr}, exp);
      errs++;
    end
    req = 8'h00;
    cyc();
    exp = {1'b0, 8'h00, 3'd0, 8'h20};
    vecs++;
    if ({grant_valid, grant_onehot, grant_id, mr_ptr} !== exp) begin
      $display("FAIL idle_load got %h want %h", {grant_valid, grant_onehot, grant_id, mr_ptr}, exp);
      errs++;
    end
  endtask

  task automatic test_n5();
    logic [13:0] exp;
    int          seq [6] = '{0, 1, 2, 3, 4, 0};
    rst5 = 1'b1;
    req5 = 5'h00;
    flush5 = 1'b0;
    ready5 = 1'b1;
    #2;
    rst5 = 1'b0;
    req5 = 5'h1F;
    for (int i = 0; i < 6; i++) begin
      cyc();
      exp = {1'b1, 5'(1 << seq[i]), 3'(seq[i]), 5'(1 << seq[i])};
      vecs++;
      if ({valid5, onehot5, id5, mr5} !== exp) begin
        $display("FAIL n5_seq[%0d] got %h want %h", i, {valid5, onehot5, id5, mr5}, exp);
        errs++;
      end
    end
    rst5 = 1'b1;
    #1;
    exp = {1'b0, 5'h00, 3'd0, 5'h10};
    vecs++;
    if ({valid5, onehot5, id5, mr5} !== exp) begin
      $display("FAIL n5_async_rst got %h want %h", {valid5, onehot5, id5, mr5}, exp);
      errs++;
    end
    rst5 = 1'b0;
    cyc();
    exp = {1'b1, 5'h01, 3'd0, 5'h01};
    vecs++;
    if ({valid5, onehot5, id5, mr5} !== exp) begin
      $display("FAIL n5_restart got %h want %h", {valid5, onehot5, id5, mr5}, exp);
      errs++;
    end
  endtask

  initial begin
    rst5 = 1'b1;
    req5 = 5'h00;
    flush5 = 1'b0;
    ready5 = 1'b0;
    test_reset();
    test_rr_all();
    test_single();
    test_backpressure();
    test_wrap();
    test_flush();
    test_n5();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
